// File: rtl/user_proj_multi_timer_if.sv
// ---------------------------------------------------------------------------
// user_proj_multi_timer_if
// Wishbone slave bus used by the multi-channel timer.
//   wbs_cyc_i / wbs_stb_i : cycle and strobe from the master
//   wbs_we_i              : 1 = write, 0 = read
//   wbs_sel_i             : byte selects, applied to every write
//   wbs_adr_i / wbs_dat_i : address and write data
//   wbs_ack_o / wbs_dat_o : one-cycle acknowledge and registered read data
// ---------------------------------------------------------------------------
interface user_proj_multi_timer_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_proj_multi_timer.sv
// ---------------------------------------------------------------------------
// user_proj_multi_timer
// CHANNELS independent BITS-wide up/down timers with compare/reload, one-shot
// or periodic mode, a match flag, an IRQ contribution and a toggling GPIO.
//
// Ports
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wb                 : Wishbone slave (user_proj_multi_timer_if.slave)
//   la_data_in/la_oenb : [ch] = hardware gate, honoured when la_oenb[ch] = 0
//   la_data_out        : channel-0 count, zero-extended
//   io_in              : unused
//   io_out/io_oeb      : [ch] = per-channel toggle output / enable (low)
//   irq                : [0] = OR over channels of flag & irq_en
//
// Register map, channel = adr[7:4], register = adr[3:2]:
//   0 CTRL   [0] en [1] down [2] periodic [3] irq_en
//   1 COUNT  2 CMP  3 STATUS [0] flag (write 1 to clear)
// ---------------------------------------------------------------------------
module user_proj_multi_timer #(
  parameter int          CHANNELS     = 4,
  parameter int          BITS         = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          MPRJ_IO_PADS = 38
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  user_proj_multi_timer_if.slave  wb,
  input  logic [63:0]             la_data_in,
  output logic [63:0]             la_data_out,
  input  logic [63:0]             la_oenb,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb,
  output logic [2:0]              irq
);

  // Handshake: a request is valid when cyc & stb & the upper address matches
  // the base. A valid request is accepted on a clock edge where ack is low;
  // ack is then high for exactly one cycle with dat_o loaded at the same edge.
  // dat_o holds until the next accepted access. Reset clears ack, so an
  // access in flight during reset is never acknowledged.
  logic        w_valid;
  logic        w_acc;
  logic        w_wr;
  logic        w_ch_ok;
  logic [3:0]  w_ch;
  logic [1:0]  w_reg;
  logic [31:0] w_rdata;

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_io_live;

  logic [CHANNELS-1:0] r_en;
  logic [CHANNELS-1:0] r_down;
  logic [CHANNELS-1:0] r_per;
  logic [CHANNELS-1:0] r_irq_en;
  logic [CHANNELS-1:0] r_flag;
  logic [CHANNELS-1:0] r_tog;
  logic [BITS-1:0]     r_count [CHANNELS];
  logic [BITS-1:0]     r_cmp   [CHANNELS];

  logic [CHANNELS-1:0] w_step;
  logic [CHANNELS-1:0] w_match;
  logic [CHANNELS-1:0] w_hit;

  assign w_valid = wb.wbs_cyc_i & wb.wbs_stb_i &
                   (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_acc   = w_valid & ~r_ack;
  assign w_wr    = w_acc & wb.wbs_we_i;
  assign w_ch    = wb.wbs_adr_i[7:4];
  assign w_reg   = wb.wbs_adr_i[3:2];
  assign w_ch_ok = ({28'd0, w_ch} < 32'(CHANNELS));

  // Byte-lane merge of a write into a register narrower than or equal to 32.
  function automatic logic [BITS-1:0] f_merge(input logic [BITS-1:0] old_v,
                                              input logic [31:0]     dat,
                                              input logic [3:0]      sel);
    logic [31:0] v;
    v = 32'(old_v);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) v[b*8 +: 8] = dat[b*8 +: 8];
    end
    return v[BITS-1:0];
  endfunction

  // Per-channel step enable, match on the pre-step value, and write decode.
  always_comb begin
    w_step  = '0;
    w_match = '0;
    w_hit   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_step[c]  = r_en[c] & ~(~la_oenb[c] & la_data_in[c]);
      w_match[c] = r_down[c] ? (r_count[c] == '0) : (r_count[c] == r_cmp[c]);
      w_hit[c]   = w_wr & w_ch_ok & (w_ch == 4'(c));
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ch_ok) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_ch == 4'(c)) begin
          case (w_reg)
            2'd0: w_rdata = {28'd0, r_irq_en[c], r_per[c], r_down[c], r_en[c]};
            2'd1: w_rdata = 32'(r_count[c]);
            2'd2: w_rdata = 32'(r_cmp[c]);
            2'd3: w_rdata = {31'd0, r_flag[c]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_io_live <= 1'b0;
      r_en      <= '0;
      r_down    <= '0;
      r_per     <= '0;
      r_irq_en  <= '0;
      r_flag    <= '0;
      r_tog     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_count[c] <= '0;
        r_cmp[c]   <= '0;
      end
    end else begin
      r_ack     <= w_acc;
      r_io_live <= 1'b1;
      if (w_acc) r_dat <= wb.wbs_we_i ? 32'd0 : w_rdata;

      for (int c = 0; c < CHANNELS; c++) begin
        // W1C first so that a same-cycle match (below) wins.
        if (w_hit[c] && (w_reg == 2'd3) && wb.wbs_sel_i[0] && wb.wbs_dat_i[0])
          r_flag[c] <= 1'b0;

        if (w_step[c]) begin
          if (w_match[c]) begin
            r_flag[c] <= 1'b1;
            r_tog[c]  <= ~r_tog[c];
            if (r_per[c]) r_count[c] <= r_down[c] ? r_cmp[c] : '0;
            else          r_en[c]    <= 1'b0;
          end else begin
            r_count[c] <= r_down[c] ? (r_count[c] - 1'b1) : (r_count[c] + 1'b1);
          end
        end

        // Bus writes come last so they override the hardware step / en clear.
        if (w_hit[c]) begin
          case (w_reg)
            2'd0: begin
              if (wb.wbs_sel_i[0]) begin
                r_en[c]     <= wb.wbs_dat_i[0];
                r_down[c]   <= wb.wbs_dat_i[1];
                r_per[c]    <= wb.wbs_dat_i[2];
                r_irq_en[c] <= wb.wbs_dat_i[3];
              end
            end
            2'd1: r_count[c] <= f_merge(r_count[c], wb.wbs_dat_i, wb.wbs_sel_i);
            2'd2: r_cmp[c]   <= f_merge(r_cmp[c], wb.wbs_dat_i, wb.wbs_sel_i);
            default: ;
          endcase
        end
      end
    end
  end

  logic [CHANNELS-1:0] w_oe_ch;
  assign w_oe_ch = {CHANNELS{r_io_live}};

  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_dat;
  assign la_data_out  = 64'(r_count[0]);
  assign io_out       = MPRJ_IO_PADS'(r_tog);
  assign io_oeb       = ~(MPRJ_IO_PADS'(w_oe_ch));
  assign irq          = {2'b00, |(r_flag & r_irq_en)};

  logic w_unused;
  assign w_unused = ^{io_in, la_data_in[63:CHANNELS], la_oenb[63:CHANNELS],
                      wb.wbs_adr_i[1:0]};

endmodule

// File: tb/tb_user_proj_multi_timer.sv
// ---------------------------------------------------------------------------
// tb_user_proj_multi_timer
// Directed bench for the multi-channel timer (4 channels, 32 bits).
// Bus tasks are called 1 ns after a rising edge; an access is accepted at the
// next edge and the task returns 1 ns after the following edge.
// ---------------------------------------------------------------------------
module tb_user_proj_multi_timer;
  localparam int PADS = 38;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  user_proj_multi_timer_if bus();
  logic [63:0]     la_data_in;
  logic [63:0]     la_oenb;
  logic [PADS-1:0] io_in;
  wire  [63:0]     la_data_out;
  wire  [PADS-1:0] io_out;
  wire  [PADS-1:0] io_oeb;
  wire  [2:0]      irq;

  user_proj_multi_timer #(
    .CHANNELS(4), .BITS(32), .BASE_ADDR(32'h3000_0000), .MPRJ_IO_PADS(PADS)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (bus),
    .la_data_in (la_data_in),
    .la_data_out(la_data_out),
    .la_oenb    (la_oenb),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;
  localparam logic [31:0] B = 32'h3000_0000;

  // ---------------- driver tasks ----------------
  task automatic wb_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input bit exp_ack, output logic [31:0] rdat);
    int n;
    bit acked;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    acked = 1'b0;
    n = 0;
    while (!acked && n < 8) begin
      tick();
      n++;
      if (bus.wbs_ack_o === 1'b1) acked = 1'b1;
    end
    rdat = bus.wbs_dat_o;
    wb_idle();
    tick();
    checks++;
    if (acked !== exp_ack) begin
      errors++;
      $display("FAIL ack adr=%h got=%0d exp=%0d", adr, acked, exp_ack);
    end
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wb_xfer(1'b1, B | off, d, sel, 1'b1, dummy);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] d);
    wb_xfer(1'b0, B | off, 32'h0, 4'hF, 1'b1, d);
  endtask

  // Read a register and compare against an expected value.
  task automatic rd_expect(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(off, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, d, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [PADS-1:0] exp_oeb;
    rst        = 1'b1;
    la_data_in = '0;
    la_oenb    = '1;
    io_in      = '0;
    wb_idle();
    repeat (3) tick();
    checks++;
    if (io_oeb !== {PADS{1'b1}}) begin errors++; $display("FAIL oeb_in_reset got=%h", io_oeb); end
    // A request presented during reset must not be acknowledged.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = B | 32'h04;
    tick();
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL ack_in_reset got=%b exp=0", bus.wbs_ack_o); end
    wb_idle();
    rst = 1'b0;
    tick();
    exp_oeb = '1;
    exp_oeb[3:0] = 4'h0;
    checks++;
    if (io_oeb !== exp_oeb) begin errors++; $display("FAIL oeb_after_reset got=%h exp=%h", io_oeb, exp_oeb); end
    checks++;
    if (irq !== 3'b000) begin errors++; $display("FAIL irq_reset got=%b exp=000", irq); end
    checks++;
    if (io_out !== '0) begin errors++; $display("FAIL io_out_reset got=%h exp=0", io_out); end
    for (int ch = 0; ch < 4; ch++)
      for (int r = 0; r < 4; r++)
        rd_expect($sformatf("reset_reg_ch%0d_r%0d", ch, r), 32'(ch * 16 + r * 4), 32'h0);
  endtask

  task automatic test_periodic_up();
    wb_write(32'h08, 32'd3);
    wb_write(32'h00, 32'h5);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) tick();
      checks++;
      if (la_data_out[31:0] !== 32'(k % 4)) begin
        errors++; $display("FAIL periodic_count k=%0d got=%0d exp=%0d", k, la_data_out[31:0], k % 4);
      end
      checks++;
      if (io_out[0] !== 1'((k / 4) % 2)) begin
        errors++; $display("FAIL periodic_toggle k=%0d got=%b exp=%0d", k, io_out[0], (k / 4) % 2);
      end
    end
    wb_write(32'h00, 32'h0);
    rd_expect("periodic_flag", 32'h0C, 32'h1);
  endtask

  task automatic test_oneshot_down();
    wb_write(32'h14, 32'd2);
    wb_write(32'h10, 32'hB);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      checks++;
      if (irq[0] !== (k == 3)) begin
        errors++; $display("FAIL down_irq k=%0d got=%b exp=%0d", k, irq[0], k == 3);
      end
    end
    checks++;
    if (io_out[1] !== 1'b1) begin errors++; $display("FAIL down_toggle got=%b exp=1", io_out[1]); end
    repeat (3) tick();
    rd_expect("down_count_hold", 32'h14, 32'h0);
    rd_expect("down_ctrl_en_clr", 32'h10, 32'hA);
    rd_expect("down_flag", 32'h1C, 32'h1);
    wb_write(32'h1C, 32'h1);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL down_irq_clear got=%b exp=0", irq[0]); end
    rd_expect("down_flag_clear", 32'h1C, 32'h0);
  endtask

  task automatic test_wrap();
    wb_write(32'h24, 32'hFFFF_FFFE);
    wb_write(32'h28, 32'h1);
    wb_write(32'h20, 32'h1);
    rd_expect("wrap_ff", 32'h24, 32'hFFFF_FFFF);
    rd_expect("wrap_one", 32'h24, 32'h1);
    rd_expect("wrap_flag", 32'h2C, 32'h1);
    rd_expect("wrap_en_clr", 32'h20, 32'h0);
    rd_expect("wrap_hold", 32'h24, 32'h1);
    checks++;
    if (io_out[2] !== 1'b1) begin errors++; $display("FAIL wrap_toggle got=%b exp=1", io_out[2]); end
  endtask

  task automatic test_w1c_race();
    wb_write(32'h04, 32'h0);
    wb_write(32'h0C, 32'h1);
    rd_expect("race_pre_clear", 32'h0C, 32'h0);
    wb_write(32'h00, 32'h5);
    repeat (2) tick();
    checks++;
    if (la_data_out[31:0] !== 32'd3) begin
      errors++; $display("FAIL race_setup got=%0d exp=3", la_data_out[31:0]);
    end
    wb_write(32'h0C, 32'h1);                // lands on the matching edge
    rd_expect("race_flag_wins", 32'h0C, 32'h1);
    wb_write(32'h00, 32'h0);
    wb_write(32'h0C, 32'h1);                // no match now, clear takes effect
    rd_expect("race_clear_alone", 32'h0C, 32'h0);
  endtask

  task automatic test_count_write();
    wb_write(32'h08, 32'd100);
    wb_write(32'h00, 32'h1);
    wb_write(32'h04, 32'd50);
    checks++;
    if (la_data_out[31:0] !== 32'd51) begin
      errors++; $display("FAIL count_write_wins got=%0d exp=51", la_data_out[31:0]);
    end
    tick();
    checks++;
    if (la_data_out[31:0] !== 32'd52) begin
      errors++; $display("FAIL count_write_next got=%0d exp=52", la_data_out[31:0]);
    end
    wb_write(32'h00, 32'h0);
  endtask

  task automatic test_gate_and_bus();
    logic [31:0] d;
    wb_write(32'h38, 32'd1000);
    wb_write(32'h34, 32'd5);
    la_oenb[3]    = 1'b0;
    la_data_in[3] = 1'b1;
    wb_write(32'h30, 32'h1);
    repeat (5) tick();
    rd_expect("gate_frozen", 32'h34, 32'd5);
    la_oenb[3] = 1'b1;                      // probe disabled: gate ignored
    repeat (3) tick();
    rd_expect("gate_released", 32'h34, 32'd8);
    wb_write(32'h30, 32'h0);
    la_data_in[3] = 1'b0;
    wb_write(32'h34, 32'h0);
    rd_expect("cmp_ch3", 32'h38, 32'd1000);
    rd_expect("ch7_read_zero", 32'h70, 32'h0);
    wb_write(32'h74, 32'h1234);
    rd_expect("ch7_write_ignored", 32'h34, 32'h0);
    wb_write(32'h38, 32'h1122_3344);
    wb_write(32'h38, 32'hAABB_CCDD, 4'b0010);
    rd_expect("byte_sel", 32'h38, 32'h1122_CC44);
    wb_xfer(1'b0, 32'h3000_0134, 32'h0, 4'hF, 1'b0, d);
    rd_expect("after_mismatch", 32'h38, 32'h1122_CC44);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_periodic_up();
    test_oneshot_down();
    test_wrap();
    test_w1c_race();
    test_count_write();
    test_gate_and_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
